bootsel: RTL
============

# bootsel

Parametrised first-stage boot selector for the iCE40 warm-boot primitive. It synchronises and debounces the user button and times a startup window. It classifies the press as none, short or long and maps each to a configurable image slot, or accepts a gateware software reboot request. It then drives `S1:S0`/`BOOT` of an `SB_WARMBOOT` instance in the top-level boot image.

## Interface
Parameters:
- `DELAY_CYCLES`, 255: startup window (cycles after reset) before the button is sampled.
- `DEBOUNCE_CYCLES`, 16: cycles the synchronised button must be stable before the debounced level changes; ≥1.
- `LONG_PRESS_CYCLES`, 4096: hold time, counted from the end of the window, that classifies a press as long; ≥1.
- `BUTTON_ACTIVE_LOW`, 1: 1 = raw pin low means pressed.
- `DEFAULT_IMAGE`, 2: slot when not pressed at window end.
- `SHORT_IMAGE`, 1: slot on short press (DFU).
- `LONG_IMAGE`, 3: slot on long press.
- `AUTO_BOOT`, 1: 1 = boot as soon as the button path decides; 0 = park in IDLE and wait for a software request.

Ports:
- `pin_clk`, in, 1: sole clock.
- `rst`, in, 1: synchronous, active-high reset.
- `pin_button`, in, 1: raw asynchronous button pin.
- `sw_req_valid`, in, 1: software reboot request.
- `sw_req_image`, in, 2: requested slot 0–3.
- `sw_req_ready`, out, 1: request accepted on `sw_req_valid & sw_req_ready`.
- `pressed`, out, 1: debounced pressed level (active-high).
- `selected`, out, 2: decided slot; valid once the state leaves DELAY/HOLD.
- `boot_s`, out, 2: to `SB_WARMBOOT` `{S1,S0}`.
- `boot`, out, 1: to `SB_WARMBOOT` `BOOT`.

## Operation
- Input path: 2-flop synchroniser. The polarity is normalised per `BUTTON_ACTIVE_LOW`. A debounce counter reloads on any mismatch between the synchronised input and `pressed`. After `DEBOUNCE_CYCLES` consecutive mismatching cycles, `pressed` toggles. Counter widths are `$clog2(param+1)`, saturating with no wrap.
- States: DELAY, HOLD, IDLE, ARM, BOOT.
- DELAY: the window counter loads `DELAY_CYCLES` on reset and decrements to 0. In the cycle it reads 0:
  - `pressed`=1 → HOLD, hold counter cleared.
  - `pressed`=0 → `selected`=`DEFAULT_IMAGE`.
- HOLD: the hold counter increments while `pressed`=1.
  - `pressed` falls before the count reaches `LONG_PRESS_CYCLES` → `selected`=`SHORT_IMAGE`.
  - Count reaches `LONG_PRESS_CYCLES` → `selected`=`LONG_IMAGE`. The block does not wait for release.
- Decision exit: with `AUTO_BOOT`=1 a decision → ARM; with `AUTO_BOOT`=0 → IDLE.
- IDLE: waits for a software request only.
- Software request: `sw_req_ready`=1 in DELAY, HOLD and IDLE, else 0. On a transfer, `selected` ← `sw_req_image` and the state → ARM. This takes priority over any button decision in the same cycle. Slot 0 (self) is legal.
- ARM: `boot_s` ← `selected`, `boot` stays 0, one cycle only → BOOT.
- BOOT: `boot`=1 held; `boot_s` held. Terminal until `rst` (normally the FPGA reconfigures first).
- Reset mid-operation, any state: return to DELAY with the window reloaded. Hold and debounce counters clear, `pressed`=0, and both synchroniser flops load "not pressed". `boot` and `boot_s` drop in the cycle after `rst` is sampled.

## Timing
- Reset values: `boot`=0, `boot_s`=0, `selected`=0, `pressed`=0, `sw_req_ready`=1 (state DELAY).
- Button to `pressed`: 2 synchroniser cycles + `DEBOUNCE_CYCLES` + 1 register cycle.
- Decision latency:
  - `boot_s` is valid one cycle after the decision or request transfer.
  - `boot` rises one cycle after that, so `boot_s` is stable for ≥1 cycle before the `boot` rising edge.
- Unpressed auto boot: `boot` rises `DELAY_CYCLES`+3 cycles after reset deasserts.
- `DELAY_CYCLES`=0: the decision is made in the first cycle after reset. `pressed` is still 0, so `DEFAULT_IMAGE` is chosen.
- Release in the same cycle the hold count reaches `LONG_PRESS_CYCLES`: long wins.

## Test plan
(`DELAY`=20, `DEBOUNCE`=4, `LONG`=50, active-low; cycle numbers count from reset deasserting)
- Button idle high → `boot_s`=2 at cycle 22 and `boot`=1 at cycle 23, with `boot_s` constant thereafter.
- Button low from cycle 0, released at cycle 40 → `pressed`=1 by cycle 8; HOLD; short; `boot_s`=1 and `boot`=1 shortly after the release is debounced.
- Button low from cycle 0 and held → long at window end + 50; `boot_s`=3 and `boot`=1 with the button still low.
- A 2-cycle glitch low at cycle 10 → `pressed` stays 0; `boot_s`=2.
- `AUTO_BOOT`=0, idle button → IDLE with `selected`=2 and `boot`=0 indefinitely. Then `sw_req_valid` with image 0 → accepted in 1 cycle; `sw_req_ready`=0 next cycle; `boot_s`=0, then `boot`=1.
- `rst` pulsed while in HOLD and again while in BOOT → `boot`=0 next cycle; the window restarts and the full 20-cycle delay is observed again.

Source files
------------

// File: rtl/bootsel.sv
// Warm-boot image selector: debounced button classified as none/short/long, or a software request, drives SB_WARMBOOT.
// Latency: boot_s one cycle after the decision or request transfer, boot one cycle later; unpressed boot at DELAY_CYCLES+3.
// Backpressure: sw_req_ready is high only in DELAY/HOLD/IDLE; once ARM is entered every request is refused until rst.
module bootsel #(
    parameter int unsigned DELAY_CYCLES      = 255,
    parameter int unsigned DEBOUNCE_CYCLES   = 16,
    parameter int unsigned LONG_PRESS_CYCLES = 4096,
    parameter bit          BUTTON_ACTIVE_LOW = 1'b1,
    parameter logic [1:0]  DEFAULT_IMAGE     = 2'd2,
    parameter logic [1:0]  SHORT_IMAGE       = 2'd1,
    parameter logic [1:0]  LONG_IMAGE        = 2'd3,
    parameter bit          AUTO_BOOT         = 1'b1
) (
    input  logic       pin_clk,
    input  logic       rst,
    input  logic       pin_button,
    input  logic       sw_req_valid,
    input  logic [1:0] sw_req_image,
    output logic       sw_req_ready,
    output logic       pressed,
    output logic [1:0] selected,
    output logic [1:0] boot_s,
    output logic       boot
);

    localparam int WIN_W  = (DELAY_CYCLES > 0) ? $clog2(DELAY_CYCLES + 1) : 1;
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [WIN_W-1:0]  WIN_INIT = WIN_W'(DELAY_CYCLES);
    localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);

    typedef enum logic [2:0] {
        ST_DELAY,
        ST_HOLD,
        ST_IDLE,
        ST_ARM,
        ST_BOOT
    } state_t;

    state_t             state_q, state_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [DB_W-1:0]    db_cnt;
    logic [1:0]         sel_d;
    logic               button_norm, sync_q, button_sync;
    logic               decide;
    logic [1:0]         decide_img;

    assign button_norm = BUTTON_ACTIVE_LOW ? ~pin_button : pin_button;

    // pressed only follows the synchronised input after it has disagreed for DEBOUNCE_CYCLES in a row
    always_ff @(posedge pin_clk) begin
        if (rst) begin
            sync_q      <= 1'b0;
            button_sync <= 1'b0;
            db_cnt      <= '0;
            pressed     <= 1'b0;
        end else begin
            sync_q      <= button_norm;
            button_sync <= sync_q;
            if (button_sync == pressed) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_MAX) begin
                pressed <= button_sync;
                db_cnt  <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        hold_d       = hold_q;
        sel_d        = selected;
        decide       = 1'b0;
        decide_img   = DEFAULT_IMAGE;
        sw_req_ready = (state_q == ST_DELAY) || (state_q == ST_HOLD) || (state_q == ST_IDLE);

        case (state_q)
            ST_DELAY: begin
                if (win_q == '0) begin
                    if (pressed) begin
                        state_d = ST_HOLD;
                        hold_d  = '0;
                    end else begin
                        decide     = 1'b1;
                        decide_img = DEFAULT_IMAGE;
                    end
                end else begin
                    win_d = win_q - 1'b1;
                end
            end
            ST_HOLD: begin
                // reaching the long threshold wins over a release seen in the same cycle
                if (hold_q == HOLD_MAX) begin
                    decide     = 1'b1;
                    decide_img = LONG_IMAGE;
                end else if (!pressed) begin
                    decide     = 1'b1;
                    decide_img = SHORT_IMAGE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_ARM:  state_d = ST_BOOT;
            default: state_d = state_q;
        endcase

        if (decide) begin
            sel_d   = decide_img;
            state_d = AUTO_BOOT ? ST_ARM : ST_IDLE;
        end

        if (sw_req_valid && sw_req_ready) begin
            sel_d   = sw_req_image;
            state_d = ST_ARM;
        end
    end

    always_ff @(posedge pin_clk) begin
        if (rst) begin
            state_q  <= ST_DELAY;
            win_q    <= WIN_INIT;
            hold_q   <= '0;
            selected <= 2'd0;
            boot_s   <= 2'd0;
            boot     <= 1'b0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            hold_q   <= hold_d;
            selected <= sel_d;
            if (state_q == ST_ARM) begin
                boot_s <= selected;
            end
            if (state_q == ST_BOOT) begin
                boot <= 1'b1;
            end
        end
    end

endmodule
